minirv_ctrl_fsm: RTL and testbench
==================================

MINIRV_CTRL_FSM -- requirements
Module: minirv_ctrl_fsm

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: run  input  1  level; 1 = execute, 0 = stop at next instruction boundary.
REQ-004 SHALL have: add, addi, lui, lw, lbu, sw, sb, jalr, illegal  input  1 each  one-hot decoded instruction class from the existing decoder (illegal = none of the others).
REQ-005 SHALL have: imem_req  output  1  fetch request; imem_ack  input  1  fetch data valid.
REQ-006 SHALL have: dmem_req  output  1  data access request; dmem_we  output  1  store; dmem_wmask  output  4  byte lanes; dmem_ack  input  1  access done.
REQ-007 SHALL have: ir_we, mdr_we, rf_we, pc_we  output  1 each  register write strobes.
REQ-008 SHALL have: pc_sel  output  1  0 = PC+4, 1 = jalr target; alu_src_imm  output  1  ALU B = immediate; wb_sel  output  2  00 ALU, 01 MEM, 10 PC+4, 11 IMM(lui); ld_byte_u  output  1  zero-extend byte load.
REQ-009 SHALL have: busy  output  1; trap  output  1  sticky illegal-instruction flag; instret  output  32  retired-instruction count.

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-011 IDLE: all strobes 0, busy=0; run=1 -> FETCH next cycle.
REQ-012 FETCH: imem_req=1 held until imem_ack; on ack cycle ir_we=1, -> DECODE; no timeout.
REQ-013 DECODE: one cycle (register-file read); illegal=1 -> TRAP, else -> EXEC.
REQ-014 EXEC: one cycle; alu_src_imm=1 for addi/lw/lbu/sw/sb/jalr, 0 for add; add/addi/lui/jalr -> WB; lw/lbu/sw/sb -> MEM.
REQ-015 MEM: dmem_req=1 held until dmem_ack; dmem_we=1 for sw/sb; dmem_wmask=1111 for sw/lw, byte lane addr[1:0]-decoded mask supplied as 0001 shifted by lane for sb/lbu (lane index input not needed: mask output is 0001 and datapath shifts).
REQ-016 MEM on ack: loads -> mdr_we=1, -> WB; stores -> pc_we=1, pc_sel=0, instret+1, -> FETCH (or IDLE if run=0).
REQ-017 WB: rf_we=1, pc_we=1 single cycle; wb_sel per REQ-008 (add/addi 00, lw/lbu 01, jalr 10, lui 11); pc_sel=1 only for jalr; ld_byte_u=1 for lbu; instret+1; -> FETCH if run=1 else IDLE.
REQ-018 run is sampled only at instruction boundaries; deasserting mid-instruction SHALL complete that instruction.
REQ-019 TRAP: trap=1, busy=0, all strobes 0; exits only via reset; run ignored.
REQ-020 All strobes SHALL be Moore outputs of state plus class, except ir_we/mdr_we/pc_we(store) which qualify on same-cycle ack.
REQ-021 instret SHALL wrap 0xFFFFFFFF -> 0 with no flag.
REQ-022 Acks arriving in states not requesting them SHALL be ignored.
REQ-023 CPI: 4 + fetch wait for ALU/jalr, 4 + both waits for stores, 5 + both waits for loads.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, all outputs 0, instret=0, trap=0, including mid-request (imem_req/dmem_req drop asynchronously).
REQ-025 First FETCH SHALL occur the cycle after the first rising edge with rst_n=1 and run=1.

Structure
REQ-026 State encoding, wb_sel codes and wmask constants SHALL live in shared package minirv_pkg.
REQ-027 Single module; no sub-module; instret counter inline.

Verification
REQ-028 addi with zero-wait acks, run=1 -> imem_req 1 cycle, ir_we at ack, rf_we+pc_we in cycle 4, instret=1.
REQ-029 lw with imem_ack delayed 3 cycles, dmem_ack delayed 2 -> imem_req high 4 cycles, dmem_req high 3 cycles, mdr_we then rf_we wb_sel=01, 5+5 cycles total.
REQ-030 sb -> dmem_we=1, dmem_wmask=0001, no rf_we, pc_we on dmem_ack, instret+1.
REQ-031 jalr -> WB with pc_sel=1, wb_sel=10; lui -> wb_sel=11.
REQ-032 illegal=1 in DECODE -> TRAP, trap=1 stays through run toggles until rst_n low.
REQ-033 rst_n low during MEM with dmem_req=1 -> dmem_req=0 same cycle, instret=0; run=0 mid-EXEC -> instruction completes then IDLE.

Source files
------------

// File: rtl/minirv_pkg.sv
// Shared definitions for the minirv multi-cycle controller: state encoding,
// instruction classes, write-back select codes and byte-lane masks.
package minirv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    ClsAdd,
    ClsAddi,
    ClsLui,
    ClsLw,
    ClsLbu,
    ClsSw,
    ClsSb,
    ClsJalr
  } cls_e;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;
  localparam logic [1:0] WbImm = 2'b11;

  localparam logic [3:0] WmaskNone = 4'b0000;
  localparam logic [3:0] WmaskWord = 4'b1111;
  // Byte accesses always present lane 0; the datapath shifts by addr[1:0].
  localparam logic [3:0] WmaskByte = 4'b0001;

  function automatic logic is_store(cls_e c);
    return (c == ClsSw) || (c == ClsSb);
  endfunction

  function automatic logic is_load(cls_e c);
    return (c == ClsLw) || (c == ClsLbu);
  endfunction

  function automatic logic is_byte(cls_e c);
    return (c == ClsLbu) || (c == ClsSb);
  endfunction

endpackage

// File: rtl/minirv_ctrl_fsm.sv
// Multi-cycle control FSM for the minirv core: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module minirv_ctrl_fsm
  import minirv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        add,
  input  logic        addi,
  input  logic        lui,
  input  logic        lw,
  input  logic        lbu,
  input  logic        sw,
  input  logic        sb,
  input  logic        jalr,
  input  logic        illegal,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic        ld_byte_u,
  output logic        busy,
  output logic        trap,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic [31:0] instret_q, instret_d;

  cls_e cls_dec;
  logic cls_valid;

  always_comb begin
    cls_dec   = ClsAdd;
    cls_valid = !illegal;
    if (add)       cls_dec = ClsAdd;
    else if (addi) cls_dec = ClsAddi;
    else if (lui)  cls_dec = ClsLui;
    else if (lw)   cls_dec = ClsLw;
    else if (lbu)  cls_dec = ClsLbu;
    else if (sw)   cls_dec = ClsSw;
    else if (sb)   cls_dec = ClsSb;
    else if (jalr) cls_dec = ClsJalr;
    else           cls_valid = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    instret_d   = instret_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_wmask  = WmaskNone;
    ir_we       = 1'b0;
    mdr_we      = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel      = WbAlu;
    ld_byte_u   = 1'b0;
    busy        = 1'b0;
    trap        = 1'b0;

    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        busy = 1'b1;
        // Class is captured here so later phases do not depend on the decoder.
        if (cls_valid) begin
          cls_d   = cls_dec;
          state_d = StExec;
        end else begin
          state_d = StTrap;
        end
      end
      StExec: begin
        busy        = 1'b1;
        alu_src_imm = !((cls_q == ClsAdd) || (cls_q == ClsLui));
        state_d     = (is_load(cls_q) || is_store(cls_q)) ? StMem : StWb;
      end
      StMem: begin
        busy       = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = is_store(cls_q);
        dmem_wmask = is_byte(cls_q) ? WmaskByte : WmaskWord;
        if (dmem_ack) begin
          if (is_store(cls_q)) begin
            // Stores retire here; there is no write-back phase.
            pc_we     = 1'b1;
            instret_d = instret_q + 32'd1;
            state_d   = run ? StFetch : StIdle;
          end else begin
            mdr_we  = 1'b1;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        busy      = 1'b1;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        pc_sel    = (cls_q == ClsJalr);
        ld_byte_u = (cls_q == ClsLbu);
        case (cls_q)
          ClsLw, ClsLbu: wb_sel = WbMem;
          ClsJalr:       wb_sel = WbPc4;
          ClsLui:        wb_sel = WbImm;
          default:       wb_sel = WbAlu;
        endcase
        instret_d = instret_q + 32'd1;
        state_d   = run ? StFetch : StIdle;
      end
      StTrap: begin
        trap = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cls_q     <= ClsAdd;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_minirv_ctrl_fsm.sv
// Self-checking bench for minirv_ctrl_fsm: a table of hand-derived instruction
// records, randomized instructions against a rule model, and trap/reset corners.
module tb_minirv_ctrl_fsm;

  localparam int CADD = 0, CADDI = 1, CLUI = 2, CLW = 3, CLBU = 4;
  localparam int CSW = 5, CSB = 6, CJALR = 7, CILL = 8;

  typedef struct {
    int         cls;
    int         wf;
    int         wm;
    bit         run_after;
    int         cycles;
    bit         mem;
    bit         rf;
    bit         mdr;
    bit         dwe;
    logic [3:0] mask;
    logic [1:0] wb;
    bit         psel;
    bit         lbu_u;
    bit         imm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, run;
  logic        add, addi, lui, lw, lbu, sw, sb, jalr, illegal;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [3:0]  dmem_wmask;
  logic        ir_we, mdr_we, rf_we, pc_we, pc_sel, alu_src_imm, ld_byte_u, busy, trap;
  logic [1:0]  wb_sel;
  logic [31:0] instret;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_instret = 32'd0;

  always #5 clk = ~clk;

  minirv_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .add        (add),
    .addi       (addi),
    .lui        (lui),
    .lw         (lw),
    .lbu        (lbu),
    .sw         (sw),
    .sb         (sb),
    .jalr       (jalr),
    .illegal    (illegal),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_wmask (dmem_wmask),
    .dmem_ack   (dmem_ack),
    .ir_we      (ir_we),
    .mdr_we     (mdr_we),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .alu_src_imm(alu_src_imm),
    .wb_sel     (wb_sel),
    .ld_byte_u  (ld_byte_u),
    .busy       (busy),
    .trap       (trap),
    .instret    (instret)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_class(input int c);
    add     = (c == CADD);
    addi    = (c == CADDI);
    lui     = (c == CLUI);
    lw      = (c == CLW);
    lbu     = (c == CLBU);
    sw      = (c == CSW);
    sb      = (c == CSB);
    jalr    = (c == CJALR);
    illegal = (c == CILL);
  endtask

  // Expected behaviour of one instruction, straight from the class rules.
  function automatic vec_t mk_exp(input int c, input int wf, input int wm, input bit ra);
    vec_t e;
    bit   ld, st;
    ld          = (c == CLW) || (c == CLBU);
    st          = (c == CSW) || (c == CSB);
    e.cls       = c;
    e.wf        = wf;
    e.wm        = wm;
    e.run_after = ra;
    e.mem       = ld || st;
    e.cycles    = 4 + wf + ((ld || st) ? wm : 0) + (ld ? 1 : 0);
    e.rf        = !st;
    e.mdr       = ld;
    e.dwe       = st;
    e.mask      = (ld || st) ? (((c == CLBU) || (c == CSB)) ? 4'b0001 : 4'b1111) : 4'b0000;
    e.wb        = ld ? 2'b01 : (c == CJALR) ? 2'b10 : (c == CLUI) ? 2'b11 : 2'b00;
    e.psel      = (c == CJALR);
    e.lbu_u     = (c == CLBU);
    e.imm       = !((c == CADD) || (c == CLUI));
    return e;
  endfunction

  // Runs one instruction with the requested ack waits and checks its trace.
  task automatic do_instr(input vec_t v, input bit rnd);
    int         idle = 0, cyc = 0, since_ir = -1;
    int         n_im = 0, n_dm = 0, n_ir = 0, n_mdr = 0, n_rf = 0, n_pc = 0, n_imm = 0;
    logic [1:0] wb_seen = 2'b00;
    logic [3:0] mask_seen = 4'b0000;
    bit         psel_seen = 1'b0, lbu_seen = 1'b0, dwe_seen = 1'b0;
    bit         started = 1'b0, done = 1'b0;
    set_class(v.cls);
    run = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      imem_ack = imem_req ? (n_im == v.wf) : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      dmem_ack = dmem_req ? (n_dm == v.wm) : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      #1;
      if (!started && imem_req) begin
        started = 1'b1;
        chk("instret_at_fetch", instret, exp_instret);
        chk("idle_gap", idle, 0);
      end
      if (!started) begin
        idle++;
      end else begin
        cyc++;
        if (imem_req) n_im++;
        if (dmem_req) begin
          n_dm++;
          mask_seen |= dmem_wmask;
          dwe_seen  |= dmem_we;
        end
        if (ir_we) begin
          n_ir++;
          since_ir = 0;
        end else if (since_ir >= 0) begin
          since_ir++;
        end
        if (since_ir == 2) run = v.run_after;
        if (mdr_we) n_mdr++;
        if (alu_src_imm) n_imm++;
        if (rf_we) begin
          n_rf++;
          wb_seen  = wb_sel;
          lbu_seen = ld_byte_u;
        end
        if (pc_we) begin
          n_pc++;
          psel_seen = pc_sel;
          done      = 1'b1;
        end
      end
    end
    if (!done) begin
      chk("instr_timeout", 0, 1);
      return;
    end
    exp_instret = exp_instret + 32'd1;
    chk("cycles", cyc, v.cycles);
    chk("imem_req_cycles", n_im, v.wf + 1);
    chk("dmem_req_cycles", n_dm, v.mem ? v.wm + 1 : 0);
    chk("ir_we_count", n_ir, 1);
    chk("mdr_we_count", n_mdr, v.mdr);
    chk("rf_we_count", n_rf, v.rf);
    chk("pc_we_count", n_pc, 1);
    chk("alu_src_imm_cycles", n_imm, v.imm);
    chk("dmem_we", dwe_seen, v.dwe);
    chk("dmem_wmask", mask_seen, v.mask);
    chk("pc_sel", psel_seen, v.psel);
    if (v.rf) begin
      chk("wb_sel", wb_seen, v.wb);
      chk("ld_byte_u", lbu_seen, v.lbu_u);
    end
    if (!v.run_after) begin
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      #1;
      chk("stopped_busy", busy, 0);
      chk("stopped_imem_req", imem_req, 0);
      chk("stopped_instret", instret, exp_instret);
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{CADDI, 0, 0, 1'b1, 4,  1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{CLW,   3, 2, 1'b1, 10, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{CSB,   0, 0, 1'b1, 4,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{CJALR, 1, 0, 1'b1, 5,  1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{CLUI,  0, 0, 1'b1, 4,  1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{CADD,  2, 0, 1'b0, 6,  1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{CLBU,  0, 0, 1'b1, 5,  1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 2'b01, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{CSW,   1, 3, 1'b0, 8,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b1};

    rst_n    = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    set_class(CADD);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_imem_req", imem_req, 0);
    chk("reset_trap", trap, 0);
    chk("reset_instret", instret, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_run0_busy", busy, 0);

    for (int i = 0; i < 8; i++) do_instr(tbl[i], 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_instr(mk_exp($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3) != 0), 1'b1);
    end

    // Illegal instruction: trap is sticky regardless of run.
    run = 1'b1;
    set_class(CILL);
    begin
      bit got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        imem_ack = imem_req;
        dmem_ack = 1'b0;
        #1;
        got = imem_req;
      end
      chk("trap_fetch_seen", got, 1);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk("trap_decode_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("trap_set", trap, 1);
    chk("trap_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run      = ~run;
      imem_ack = 1'($urandom_range(0, 1));
      #1;
      chk("trap_hold", {trap, busy, imem_req, pc_we}, 4'b1000);
    end
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("trap_cleared_by_reset", trap, 0);
    chk("trap_reset_instret", instret, 0);
    exp_instret = 32'd0;
    imem_ack    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a data access.
    do_instr(mk_exp(CADDI, 0, 0, 1'b1), 1'b0);
    set_class(CLW);
    begin
      bit hit = 1'b0;
      for (int t = 0; t < 40 && !hit; t++) begin
        @(negedge clk);
        imem_ack = imem_req;
        dmem_ack = 1'b0;
        #1;
        if (dmem_req) begin
          hit = 1'b1;
          chk("pre_reset_instret", instret, 1);
          rst_n = 1'b0;
          #1;
          chk("async_dmem_req_drop", dmem_req, 0);
          chk("async_busy_drop", busy, 0);
          chk("async_instret_clear", instret, 0);
        end
      end
      chk("mem_reset_reached", hit, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
